sipo_nbit: RTL and testbench

//   Serial-in/parallel-out deserializer that feeds the n-bit parallel register stage.

---
 rtl/registers_pkg.sv | 30 +++
 rtl/sipo_nbit_if.sv | 29 ++
 rtl/sipo_shift_core.sv | 71 +++++++
 rtl/sipo_nbit.sv | 88 ++++++++
 tb/tb_sipo_nbit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/registers_pkg.sv
// Shared constants and helpers for the SIPO deserializer.
// SIPO_PARITY_EN (define) adds a trailing even-parity bit to each serial frame.
`ifndef REGISTERS_PKG_SV
`define REGISTERS_PKG_SV

`ifdef SIPO_PARITY_EN
`define SIPO_FRAME_LEN(n) ((n) + 1)
`else
`define SIPO_FRAME_LEN(n) (n)
`endif

package registers_pkg;

  localparam bit SIPO_LSB_FIRST = 1'b1;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/sipo_nbit_if.sv
// Serial input and parallel output handshake bundle for sipo_nbit.
// SIPO_PARITY_EN widens the frame by one bit, which sizes bit_count_out.
interface sipo_nbit_if
  import registers_pkg::*;
#(
  parameter int N = 4
);
  localparam int F  = `SIPO_FRAME_LEN(N);
  localparam int CW = clog2(F + 1);

  logic          serial_in;
  logic          serial_valid_in;
  logic          serial_ready_out;
  logic [N-1:0]  par_out;
  logic          par_valid_out;
  logic          par_ready_in;
  logic          parity_err_out;
  logic [CW-1:0] bit_count_out;

  modport master (
    output serial_in, serial_valid_in, par_ready_in,
    input  serial_ready_out, par_out, par_valid_out, parity_err_out, bit_count_out
  );

  modport slave (
    input  serial_in, serial_valid_in, par_ready_in,
    output serial_ready_out, par_out, par_valid_out, parity_err_out, bit_count_out
  );
endinterface

// File: rtl/sipo_shift_core.sv
// Shift register, bit counter and frame-full flag of the deserializer.
// SIPO_PARITY_EN adds a running parity accumulator; the parity bit is never stored in sr.
module sipo_shift_core
  import registers_pkg::*;
#(
  parameter  int N  = 4,
  localparam int F  = `SIPO_FRAME_LEN(N),
  localparam int CW = clog2(F + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          accept,
  input  logic          bit_in,
  input  logic          transfer,
  output logic [N-1:0]  sr,
  output logic [CW-1:0] count,
`ifdef SIPO_PARITY_EN
  output logic          par_acc,
`endif
  output logic          full
);
  logic [N-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          pacc_q, pacc_d;

  function automatic logic [N-1:0] shift_in(input logic [N-1:0] s, input logic b);
    if (SIPO_LSB_FIRST) return {b, s[N-1:1]};
    else                return {s[N-2:0], b};
  endfunction

  // An accept while full only happens alongside a transfer, so it opens the next frame.
  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    pacc_d = pacc_q;
    if (transfer) begin
      full_d = 1'b0;
      cnt_d  = '0;
      pacc_d = 1'b0;
    end
    if (accept) begin
      if (transfer || (cnt_q < CW'(N))) sr_d = shift_in(sr_q, bit_in);
      cnt_d  = cnt_d + CW'(1);
      pacc_d = pacc_d ^ bit_in;
      if (cnt_d == CW'(F)) full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
      pacc_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
      pacc_q <= pacc_d;
    end
  end

  assign sr    = sr_q;
  assign count = cnt_q;
  assign full  = full_q;
`ifdef SIPO_PARITY_EN
  assign par_acc = pacc_q;
`endif
endmodule

// File: rtl/sipo_nbit.sv
// Serial-in/parallel-out deserializer: LSB-first shift stage decoupled from a registered output.
// SIPO_PARITY_EN enables the even-parity frame bit and the registered parity_err_out flag.
module sipo_nbit
  import registers_pkg::*;
#(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       reset_ah_in,
  sipo_nbit_if.slave bus
);
  localparam int F  = `SIPO_FRAME_LEN(N);
  localparam int CW = clog2(F + 1);

  logic [N-1:0]  sr;
  logic [CW-1:0] count;
  logic          full;
  logic          out_free;
  logic          accept;
  logic          transfer;
  logic [N-1:0]  par_q, par_d;
  logic          pv_q, pv_d;
`ifdef SIPO_PARITY_EN
  logic          par_acc;
  logic          perr_q, perr_d;
`endif

  // The only combinational input-to-output path is par_ready_in -> serial_ready_out.
  assign out_free = !pv_q || bus.par_ready_in;
  assign transfer = full && out_free;
  assign accept   = bus.serial_valid_in && bus.serial_ready_out;

  sipo_shift_core #(.N(N)) u_core (
    .clk      (clk),
    .rst      (reset_ah_in),
    .accept   (accept),
    .bit_in   (bus.serial_in),
    .transfer (transfer),
    .sr       (sr),
    .count    (count),
`ifdef SIPO_PARITY_EN
    .par_acc  (par_acc),
`endif
    .full     (full)
  );

  always_comb begin
    par_d = par_q;
    pv_d  = pv_q;
    if (transfer) begin
      par_d = sr;
      pv_d  = 1'b1;
    end else if (pv_q && bus.par_ready_in) begin
      pv_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset_ah_in) begin
    if (reset_ah_in) begin
      par_q <= '0;
      pv_q  <= 1'b0;
    end else begin
      par_q <= par_d;
      pv_q  <= pv_d;
    end
  end

`ifdef SIPO_PARITY_EN
  always_comb begin
    perr_d = perr_q;
    if (transfer) perr_d = par_acc;
  end

  always_ff @(posedge clk or posedge reset_ah_in) begin
    if (reset_ah_in) perr_q <= 1'b0;
    else             perr_q <= perr_d;
  end

  assign bus.parity_err_out = perr_q;
`else
  assign bus.parity_err_out = 1'b0;
`endif

  assign bus.serial_ready_out = !full || out_free;
  assign bus.par_out          = par_q;
  assign bus.par_valid_out    = pv_q;
  assign bus.bit_count_out    = count;
endmodule

// File: tb/tb_sipo_nbit.sv
// Scoreboard bench for sipo_nbit (N=4); builds with or without SIPO_PARITY_EN.
module tb_sipo_nbit;
  import registers_pkg::*;

  localparam int N  = 4;
  localparam int F  = `SIPO_FRAME_LEN(N);
  localparam int CW = clog2(F + 1);

  typedef struct {
    logic [N-1:0] word;
    logic         perr;
    bit           chk_lat;
    int           last_cyc;
    int           gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  int   stalls = 0;
  int   last_pop = 0;
  exp_t sb[$];

  sipo_nbit_if #(.N(N)) sif ();

  sipo_nbit #(.N(N)) dut (
    .clk         (clk),
    .reset_ah_in (rst),
    .bus         (sif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Output monitor: a word is consumed at the edge following a negedge with valid & ready.
  always @(negedge clk) begin
    if (!rst && sif.par_valid_out && sif.par_ready_in) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("par_out", sif.par_out, e.word);
        check_eq("parity_err", sif.parity_err_out, e.perr);
        if (e.chk_lat) check_eq("latency", cyc - e.last_cyc, 1);
        if (e.gap != 0) check_eq("word_gap", cyc - last_pop, e.gap);
      end
      last_pop = cyc;
    end
  end

  function automatic logic frame_bit(input logic [N-1:0] w, input bit good, input int i);
    if (i < N) return w[i];
    return good ? ^w : ~^w;
  endfunction

  task automatic send_bit(input logic b);
    bit done;
    done = 0;
    sif.serial_in       = b;
    sif.serial_valid_in = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (sif.serial_ready_out) begin
        @(posedge clk);
        #1;
        done = 1;
      end else begin
        stalls++;
      end
    end
    if (!done) check_eq("send_timeout", 0, 1);
  endtask

  task automatic push_exp(input logic [N-1:0] w, input bit good, input bit lat, input int gap);
    exp_t e;
    e.word     = w;
`ifdef SIPO_PARITY_EN
    e.perr     = !good;
`else
    e.perr     = 1'b0;
`endif
    e.chk_lat  = lat;
    e.last_cyc = cyc;
    e.gap      = gap;
    sb.push_back(e);
  endtask

  task automatic send_word(input logic [N-1:0] w, input bit good, input bit lat, input int gap);
    for (int i = 0; i < F; i++) send_bit(frame_bit(w, good, i));
    push_exp(w, good, lat, gap);
  endtask

  task automatic idle(input int n);
    sif.serial_valid_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] gw;
    rst                 = 1'b1;
    sif.serial_in       = 1'b0;
    sif.serial_valid_in = 1'b0;
    sif.par_ready_in    = 1'b0;
    #12;
    check_eq("rst_count", sif.bit_count_out, 0);
    check_eq("rst_valid", sif.par_valid_out, 0);
    check_eq("rst_par", sif.par_out, 0);
    check_eq("rst_perr", sif.parity_err_out, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_ready", sif.serial_ready_out, 1);

    // Reset mid-word with a pending output word
    send_word(4'h9, 1, 0, 0);
    send_bit(1'b1);
    send_bit(1'b0);
    sif.serial_valid_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_count", sif.bit_count_out, 0);
    check_eq("midrst_valid", sif.par_valid_out, 0);
    check_eq("midrst_par", sif.par_out, 0);
    sb.delete();
    @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    sif.par_ready_in = 1'b1;
    send_word(4'b1011, 1, 1, 0);
    idle(3);

    // Streaming back-to-back
    stalls = 0;
    send_word(4'hA, 1, 1, 0);
    send_word(4'h5, 1, 1, F);
    send_word(4'hF, 1, 1, F);
    check_eq("stream_stalls", stalls, 0);
    idle(3);

    // Backpressure
    sif.par_ready_in = 1'b0;
    send_word(4'h3, 1, 0, 0);
    send_word(4'hC, 1, 0, 0);
    sif.serial_valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("bp_ready", sif.serial_ready_out, 0);
      check_eq("bp_par", sif.par_out, 4'h3);
      check_eq("bp_count", sif.bit_count_out, F);
    end
    @(posedge clk); #1;
    sif.par_ready_in = 1'b1;
    idle(3);

    // Gaps: valid toggles 1/0, count holds during the idle cycles
    gw = 4'h6;
    for (int i = 0; i < F; i++) begin
      send_bit(frame_bit(gw, 1, i));
      sif.serial_valid_in = 1'b0;
      if (i == F - 1) push_exp(gw, 1, 1, 0);
      @(negedge clk);
      check_eq("gap_count", sif.bit_count_out, i + 1);
      if (i < F - 1) begin
        @(posedge clk); #1;
        check_eq("gap_hold", sif.bit_count_out, i + 1);
      end
    end
    idle(3);

    // Parity good then bad (flag stays 0 without the parity option)
    send_word(4'h7, 1, 1, 0);
    idle(2);
    send_word(4'h7, 0, 1, 0);
    idle(3);

    // Consume and transfer in the same cycle
    sif.par_ready_in = 1'b0;
    send_word(4'h9, 1, 0, 0);
    send_word(4'h2, 1, 0, 0);
    sif.serial_valid_in = 1'b0;
    @(posedge clk); #1;
    sif.par_ready_in = 1'b1;
    @(negedge clk);
    check_eq("ct_valid0", sif.par_valid_out, 1);
    @(negedge clk);
    check_eq("ct_valid1", sif.par_valid_out, 1);
    @(negedge clk);
    check_eq("ct_drain", sif.par_valid_out, 0);
    idle(2);

    check_eq("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
